// File: rtl/count_monitor.sv
// count_monitor: checks that an incrementing count stream arrives in order.
// Ports: clk, rst_n (sync, active-low), in_valid/in_data/in_ready handshake,
//   last_value, err_count (saturating), done, fault, finish_req (pulse).
// Optional COUNT_MONITOR_STOP_ON_ERROR_EN: first mismatch halts in FAULT.
module count_monitor #(
  parameter int WIDTH = 32,
  parameter int START = 0,
  parameter int LIMIT = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [WIDTH-1:0] last_value,
  output logic [15:0]      err_count,
  output logic             done,
  output logic             fault,
  output logic             finish_req
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE,
    FAULT
  } state_t;

  localparam logic [WIDTH-1:0] START_V = WIDTH'(START);
  localparam logic [31:0]      LIMIT_V = 32'(LIMIT);

`ifdef COUNT_MONITOR_STOP_ON_ERROR_EN
  localparam bit STOP_EN = 1'b1;
`else
  localparam bit STOP_EN = 1'b0;
`endif

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] expected;
  logic [31:0]      accepted;
  logic [31:0]      accepted_nx;
  logic             accept;
  logic             mismatch;
  logic             limit_hit;

  // in_ready is a register, so it is only ever high in IDLE/RUN.
  assign accept   = in_valid & in_ready;
  assign mismatch = accept & (in_data != expected);

  always_comb begin
    accepted_nx = accepted;
    if (accept && (accepted != 32'hFFFF_FFFF))
      accepted_nx = accepted + 32'd1;
  end

  assign limit_hit = accept & (LIMIT_V != 32'd0)
                   & (accepted_nx == LIMIT_V);

  // Fault beats done when both happen on the same word.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, RUN: begin
        if (accept) begin
          if (STOP_EN && mismatch)
            state_nx = FAULT;
          else if (limit_hit)
            state_nx = DONE;
          else
            state_nx = RUN;
        end
      end
      DONE:  state_nx = DONE;
      FAULT: state_nx = FAULT;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      in_ready   <= 1'b0;
      expected   <= START_V;
      accepted   <= 32'd0;
      last_value <= '0;
      err_count  <= 16'd0;
      done       <= 1'b0;
      finish_req <= 1'b0;
    end else begin
      state      <= state_nx;
      in_ready   <= (state_nx == IDLE) || (state_nx == RUN);
      done       <= (state_nx == DONE);
      finish_req <= (state_nx == DONE) && (state != DONE);
      if (accept) begin
        // Resync on every word so one glitch counts as one error.
        expected   <= in_data + WIDTH'(1);
        last_value <= in_data;
        accepted   <= accepted_nx;
        if (mismatch && (err_count != 16'hFFFF))
          err_count <= err_count + 16'd1;
      end
    end
  end

`ifdef COUNT_MONITOR_STOP_ON_ERROR_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      fault <= 1'b0;
    else
      fault <= (state_nx == FAULT);
  end
`else
  assign fault = 1'b0;
`endif

endmodule

// File: doc/count_monitor.md
COUNT_MONITOR -- requirements
Module: count_monitor

Interface
REQ-001 Parameter WIDTH, default 32, width of the observed value stream.
REQ-002 Parameter START, default 0, value expected as the first accepted word after reset.
REQ-003 Parameter LIMIT, default 5, number of accepted words after which the monitor finishes; LIMIT=0 means never finish.
REQ-004 clk  input  1  sole clock; all state changes on posedge clk.
REQ-005 rst_n  input  1  synchronous, active-low reset, sampled on posedge clk.
REQ-006 in_valid  input  1  producer presents a word on in_data.
REQ-007 in_data  input  WIDTH  observed count value.
REQ-008 in_ready  output  1  monitor can accept a word this cycle.
REQ-009 last_value  output  WIDTH  most recently accepted word.
REQ-010 err_count  output  16  number of sequence mismatches, saturating.
REQ-011 done  output  1  level, high while in DONE.
REQ-012 fault  output  1  level, high while in FAULT.
REQ-013 finish_req  output  1  single-cycle pulse on entry to DONE.

Function
REQ-014 Accept SHALL occur on a posedge where in_valid=1 and in_ready=1; no other condition consumes a word.
REQ-015 FSM states SHALL be IDLE, RUN, DONE and FAULT; in_ready=1 in IDLE and RUN only.
REQ-016 IDLE -> RUN on first accept; RUN stays RUN on accept until the finish or fault condition.
REQ-017 Internal expected register SHALL be START after reset and in_data+1 (mod 2^WIDTH) after every accept, match or not (resync).
REQ-018 Mismatch = accepted in_data != expected; wrap 2^WIDTH-1 -> 0 is a match.
REQ-019 Accepted-word counter SHALL be 32 bits, saturating; when it reaches LIMIT (LIMIT>=1), next state SHALL be DONE.
REQ-020 DONE and FAULT SHALL be terminal until reset; in_valid ignored there.
REQ-021 finish_req SHALL be high exactly one cycle, the first cycle done is high.
REQ-022 All outputs SHALL be registered; last_value, err_count, done, fault SHALL reflect an accept on the cycle after the accepting edge.
REQ-023 err_count SHALL increment by 1 per mismatch and hold at 16'hFFFF.
REQ-024 Simultaneous mismatch and LIMIT reach: mismatch counted; FAULT takes priority over DONE when fault-stop is compiled in, otherwise DONE.
REQ-025 in_valid held high while in_ready=0 SHALL not alter any state.

Reset
REQ-026 rst_n=0 at posedge SHALL force IDLE, expected=START, counter=0, last_value=0, err_count=0, done=0, fault=0, finish_req=0, in_ready=0 for that cycle.
REQ-027 Reset asserted mid-stream (any state, including DONE/FAULT) SHALL discard the in-flight word and return fully to REQ-026 values; in_ready=1 the cycle after rst_n returns high.

Configuration
REQ-028 Macro COUNT_MONITOR_STOP_ON_ERROR_EN defined: first mismatch moves FSM to FAULT (fault=1, in_ready=0) on the following cycle, err_count=1.
REQ-029 Macro undefined: FAULT state unreachable, fault tied 0, mismatches only counted and the stream continues.

Verification
REQ-030 Reset, then stream 0,1,2,3,4 back-to-back (START=0, LIMIT=5) -> err_count=0, last_value=4, done=1, finish_req one-cycle pulse one cycle after the 5th accept.
REQ-031 Stream 0,1,5,6,7 without macro -> err_count=1, done=1, last_value=7; with macro -> fault=1 after word 5, in_ready=0, last_value=5, done=0.
REQ-032 WIDTH=8, START=8'hFE, LIMIT=3, stream FE,FF,00 -> err_count=0, done=1 (wrap accepted).
REQ-033 Hold in_valid=1 with gaps (in_valid toggled 1,0,1) and words 0,1 -> only 2 accepts, last_value=1, state RUN, done=0; after DONE, further in_valid with 9 -> last_value unchanged.
REQ-034 Assert rst_n=0 after 3 accepts of 0,1,2, release, stream 0..4 -> no error, done after 5 new accepts, err_count=0.
REQ-035 LIMIT=0, stream 0..9 -> done never asserts, err_count=0, last_value=9.
